// File: rtl/stream_mux_rr_pkg.sv
// Shared constants for the round-robin / fixed-select stream multiplexer.
package stream_mux_pkg;

  localparam logic MODE_MUX = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  localparam int CNT_W = 16;

endpackage

// File: rtl/stream_mux_rr_if.sv
// Input and output handshake bundle of the stream multiplexer.
// The master modport is the multiplexer itself; slave is the
// surrounding logic that drives the sources and the sink.
interface stream_mux_rr_if #(
  parameter int WIDTH = 8,
  parameter int N     = 2,
  localparam int SEL_W = $clog2(N)
) ();

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_chan;
  logic               out_valid;
  logic               out_ready;

  modport master (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational rotating-priority search: the first requester found
// starting at ptr and moving upward modulo N wins.
module rr_arbiter #(
  parameter int N = 2,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     grant_oh,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_vld
);

  function automatic int wrap_idx(input int p, input int i);
    return (p + i) % N;
  endfunction

  // Walk the channels from ptr and stop at the first requester.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        if (!grant_vld && req[wrap_idx(int'(ptr), i)]) begin
          grant_vld                        = 1'b1;
          grant_idx                        = SEL_W'(wrap_idx(int'(ptr), i));
          grant_oh[wrap_idx(int'(ptr), i)] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// Registered N-channel stream multiplexer with fixed-select and
// round-robin modes, a one-deep output register and a beat counter.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 2,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  stream_mux_rr_if.master    bus,
  input  logic [SEL_W-1:0]   sel,
  input  logic               mode,
  output logic [CNT_W-1:0]   xfer_cnt
);

  logic [SEL_W-1:0] rr_ptr;
  logic [N-1:0]     arb_oh;
  logic [SEL_W-1:0] arb_idx;
  logic             arb_vld;
  logic [N-1:0]     mux_oh;
  logic [N-1:0]     grant_oh;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             load;
  logic             in_xfer;
  logic             out_xfer;

  rr_arbiter #(.N(N)) u_arb (
    .req       (bus.in_valid),
    .ptr       (rr_ptr),
    .en        (mode == MODE_RR),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  // Fixed-select grant; an out-of-range sel matches no channel.
  always_comb begin
    mux_oh = '0;
    for (int k = 0; k < N; k++) begin
      mux_oh[k] = (sel == SEL_W'(k)) && bus.in_valid[k];
    end
  end

  assign grant_oh  = (mode == MODE_RR) ? arb_oh  : mux_oh;
  assign grant_idx = (mode == MODE_RR) ? arb_idx : sel;

  // Pick the granted channel's data slice.
  always_comb begin
    grant_data = '0;
    for (int k = 0; k < N; k++) begin
      if (grant_oh[k]) grant_data = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  assign load         = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = (rst || !load) ? '0 : grant_oh;
  assign in_xfer      = |(bus.in_valid & bus.in_ready);
  assign out_xfer     = bus.out_valid && bus.out_ready;

  // Output register, round-robin pointer and accepted-beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_chan  <= '0;
      rr_ptr        <= '0;
      xfer_cnt      <= '0;
    end else begin
      if (in_xfer) begin
        bus.out_data  <= grant_data;
        bus.out_chan  <= grant_idx;
        bus.out_valid <= 1'b1;
        if (mode == MODE_RR) begin
          rr_ptr <= (grant_idx == SEL_W'(N-1)) ? '0 : grant_idx + 1'b1;
        end
      end else if (out_xfer) begin
        bus.out_valid <= 1'b0;
      end
      if (out_xfer) xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised, registered N-channel, WIDTH-bit stream multiplexer; successor to the fixed 8-bit 2:1 combinational mux in the ALU operand path.
- Adds a valid/ready handshake on every input and on the output, plus a one-deep output register.
- Two modes: fixed select (MUX) and round-robin arbitration (RR).
- Sits between operand sources (register file, immediate, forwarded result) and the ALU input stage.

Parameters:
- WIDTH, 8, data width per channel in bits (>=1).
- N, 2, number of input channels (>=2).
- SEL_W, $clog2(N), width of the select and channel-ID fields (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; at most one bit is high per cycle.
- sel  in  SEL_W  channel index used in MUX mode.
- mode  in  1  0 = MUX (fixed select), 1 = RR (round robin).
- out_data  out  WIDTH  registered selected data.
- out_chan  out  SEL_W  index of the channel that supplied out_data.
- out_valid  out  1  output holds a beat.
- out_ready  in  1  downstream accepts the beat.
- xfer_cnt  out  16  count of accepted output beats; wraps at 2^16.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_chan=0, xfer_cnt=0, rr_ptr=0. in_ready is forced to all-zero while rst=1.
- Load condition: load = !out_valid || out_ready. Only the single granted channel's in_ready equals load; all other in_ready bits are 0.
- Input transfer on channel k: in_valid[k] && in_ready[k]. At the same edge: out_data <= chan k data, out_chan <= k, out_valid <= 1.
- Output transfer: out_valid && out_ready. If no input transfer happens in the same cycle, out_valid <= 0. Accepting a new beat in the same cycle is allowed, giving full throughput of one beat per clock.
- Latency: an input is accepted at edge t and its data appears on out_data immediately after edge t (1 cycle).
- Hold rule: while out_valid=1 and out_ready=0, out_data and out_chan are stable and all in_ready bits are 0.
- MUX mode grant:
  - grant = sel when sel < N and in_valid[sel]=1; otherwise no grant.
  - sel >= N (possible when N is not a power of 2) never grants and never hangs: the output simply drains.
- RR mode grant:
  - grant = the first k with in_valid[k]=1, searching rr_ptr, rr_ptr+1, ... modulo N.
  - After an input transfer from channel g, rr_ptr <= (g+1) mod N, with wrap from N-1 to 0.
  - rr_ptr is unchanged in MUX mode and on cycles with no transfer.
- Mode or sel change: takes effect combinationally in the same cycle. A beat already held in the output register is not affected.
- xfer_cnt increments on each output transfer and wraps from 0xFFFF to 0.
- Reset mid-operation: a held beat is discarded (out_valid=0). Upstream sees in_ready=0 during reset, so no beat is lost there.
- in_valid is allowed to drop without a transfer; the block does not require sources to hold valid.

Decomposition:
- Package stream_mux_pkg holds:
  - MODE_MUX=1'b0 and MODE_RR=1'b1.
  - The xfer_cnt width constant CNT_W=16.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N], ptr[SEL_W], en.
  - Outputs: grant_oh[N], grant_idx[SEL_W], grant_vld.
  - Purely combinational rotate/priority search.
- The top level holds rr_ptr, the output register, the handshake logic and the counter.

Test Plan:
- Reset, WIDTH=8, N=2 → out_valid=0, in_ready=2'b00, xfer_cnt=0. Release reset; MUX mode, sel=1, in_data={8'hA5,8'h3C}, in_valid=2'b11, out_ready=1 → in_ready=2'b10; next cycle out_data=8'hA5, out_chan=1.
- Back-pressure: hold out_ready=0 for 3 cycles after one beat → out_data stable, in_ready=0 throughout. Raise out_ready → 1 beat per cycle resumes and xfer_cnt advances by 1 per beat.
- RR mode, N=4, all in_valid=1, out_ready=1 for 8 cycles → out_chan sequence 0,1,2,3,0,1,2,3.
- RR mode, N=4, in_valid=4'b1010 → out_chan alternates 1,3,1,3; rr_ptr wraps 3→0 correctly.
- N=3, MUX mode, sel=3 → in_ready=0 and out_valid falls to 0 after drain. Then assert rst for 1 cycle while holding a beat with out_ready=0 → out_valid=0 on the next cycle.
- xfer_cnt wrap: 65536 output transfers → xfer_cnt returns to 0.
